// File: rtl/x1_sub_port.sv
// rtl/x1_sub_port.sv - X1 main-to-sub CPU port: command handshake, response FIFO, busy flags
// Z80 I/O writes become sub-CPU commands; sub-CPU responses are queued for Z80 reads.
module x1_sub_port_rsp_fifo #(
  parameter int AW = 2
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);
  localparam int DEPTH = 1 << AW;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == DEPTH[AW:0]);
  assign empty = (count == '0);
endmodule

module x1_sub_port #(
  parameter int RX_AW = 2
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       cs,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  output logic       cpu_doe,
  output logic [7:0] sub_cmd,
  output logic       sub_cmd_valid,
  input  logic       sub_cmd_ack,
  input  logic [7:0] sub_rsp,
  input  logic       sub_rsp_valid,
  output logic       sub_rsp_ready,
  output logic       tx_bsy,
  output logic       rx_bsy,
  output logic       tx_drop
);
  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_PEND = 1'b1
  } tx_state_t;

  tx_state_t  tx_state;
  logic       wr_q;
  logic       rd_q;
  logic       rd_had_data;
  logic       wr_act;
  logic       rd_act;
  logic       wr_start;
  logic       rd_start;
  logic       rd_end;
  logic       fifo_push;
  logic       fifo_pop;
  logic [7:0] fifo_head;
  logic       fifo_full;
  logic       fifo_empty;

  // Strobes are held for many clk_sys cycles, so act only on their edges.
  assign wr_act   = cs & ~wr_n;
  assign rd_act   = cs & ~rd_n;
  assign wr_start = wr_act & ~wr_q;
  assign rd_start = rd_act & ~rd_q;
  assign rd_end   = ~rd_act & rd_q;

  assign fifo_push = sub_rsp_valid & ~fifo_full;
  assign fifo_pop  = rd_end & rd_had_data;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tx_state    <= TX_IDLE;
      sub_cmd     <= 8'h00;
      tx_drop     <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      cpu_dout    <= 8'hFF;
      cpu_doe     <= 1'b0;
      rd_had_data <= 1'b0;
    end else begin
      wr_q    <= wr_act;
      rd_q    <= rd_act;
      cpu_doe <= rd_act;
      tx_drop <= 1'b0;

      if (tx_state == TX_IDLE) begin
        if (wr_start) begin
          sub_cmd  <= cpu_din;
          tx_state <= TX_PEND;
        end
      end else begin
        if (wr_start) begin
          tx_drop <= 1'b1;
        end
        if (sub_cmd_ack) begin
          tx_state <= TX_IDLE;
        end
      end

      // Remember whether this access saw data so an empty read never pops.
      if (rd_start) begin
        cpu_dout    <= fifo_empty ? 8'hFF : fifo_head;
        rd_had_data <= ~fifo_empty;
      end else if (rd_end) begin
        rd_had_data <= 1'b0;
      end
    end
  end

  assign sub_cmd_valid = (tx_state == TX_PEND);
  assign tx_bsy        = (tx_state == TX_PEND);
  assign sub_rsp_ready = ~fifo_full;
  assign rx_bsy        = fifo_empty;

  x1_sub_port_rsp_fifo #(
    .AW(RX_AW)
  ) u_rsp_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wdata   (sub_rsp),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );
endmodule

// File: tb/tb_x1_sub_port.sv
// tb/tb_x1_sub_port.sv - self-checking bench for x1_sub_port
// Inputs change and outputs are sampled on the falling edge of clk_sys.
module tb_x1_sub_port;
  logic       clk_sys = 1'b0;
  logic       reset;
  logic       cs;
  logic       rd_n;
  logic       wr_n;
  logic [7:0] cpu_din;
  logic [7:0] cpu_dout;
  logic       cpu_doe;
  logic [7:0] sub_cmd;
  logic       sub_cmd_valid;
  logic       sub_cmd_ack;
  logic [7:0] sub_rsp;
  logic       sub_rsp_valid;
  logic       sub_rsp_ready;
  logic       tx_bsy;
  logic       rx_bsy;
  logic       tx_drop;

  always #5 clk_sys = ~clk_sys;

  x1_sub_port #(.RX_AW(2)) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .cs            (cs),
    .rd_n          (rd_n),
    .wr_n          (wr_n),
    .cpu_din       (cpu_din),
    .cpu_dout      (cpu_dout),
    .cpu_doe       (cpu_doe),
    .sub_cmd       (sub_cmd),
    .sub_cmd_valid (sub_cmd_valid),
    .sub_cmd_ack   (sub_cmd_ack),
    .sub_rsp       (sub_rsp),
    .sub_rsp_valid (sub_rsp_valid),
    .sub_rsp_ready (sub_rsp_ready),
    .tx_bsy        (tx_bsy),
    .rx_bsy        (rx_bsy),
    .tx_drop       (tx_drop)
  );

  int errors = 0;
  int checks = 0;
  int mdl_cnt = 0;
  logic [7:0] rsp_q[$];
  logic [7:0] cmd_q[$];

  typedef struct {
    logic       is_read;
    logic [7:0] din;
    logic       exp_ready;
    logic       exp_rx_bsy;
  } vec_t;

  vec_t vt[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_sys);
  endtask

  task automatic do_push(input logic [7:0] d);
    sub_rsp       = d;
    sub_rsp_valid = 1'b1;
    if (mdl_cnt < 4) begin
      rsp_q.push_back(d);
      mdl_cnt++;
    end
    tick();
    sub_rsp_valid = 1'b0;
  endtask

  task automatic do_read(input int hold, input string name);
    logic [7:0] exp;
    exp = 8'hFF;
    if (rsp_q.size() > 0) begin
      exp = rsp_q.pop_front();
      mdl_cnt--;
    end
    cs   = 1'b1;
    rd_n = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      check({name, "_dout"}, cpu_dout, exp);
      check({name, "_doe"}, cpu_doe, 1'b1);
    end
    cs   = 1'b0;
    rd_n = 1'b1;
    tick();
    check({name, "_doe_off"}, cpu_doe, 1'b0);
  endtask

  task automatic cmd_ack(input string name);
    logic [7:0] exp;
    exp = 8'h00;
    if (cmd_q.size() > 0) exp = cmd_q.pop_front();
    check({name, "_cmd"}, sub_cmd, exp);
    sub_cmd_ack = 1'b1;
    tick();
    sub_cmd_ack = 1'b0;
    check({name, "_tx_bsy_off"}, tx_bsy, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int drops;

    vt[0] = '{1'b0, 8'hA1, 1'b1, 1'b1};
    vt[1] = '{1'b0, 8'hA2, 1'b1, 1'b0};
    vt[2] = '{1'b0, 8'hA3, 1'b1, 1'b0};
    vt[3] = '{1'b0, 8'hA4, 1'b1, 1'b0};
    vt[4] = '{1'b0, 8'hA5, 1'b0, 1'b0};
    vt[5] = '{1'b1, 8'h00, 1'b0, 1'b0};
    vt[6] = '{1'b1, 8'h00, 1'b1, 1'b0};
    vt[7] = '{1'b1, 8'h00, 1'b1, 1'b0};
    vt[8] = '{1'b1, 8'h00, 1'b1, 1'b0};
    vt[9] = '{1'b1, 8'h00, 1'b1, 1'b1};

    reset = 1'b1; cs = 1'b0; rd_n = 1'b1; wr_n = 1'b1; cpu_din = 8'h00;
    sub_cmd_ack = 1'b0; sub_rsp = 8'h00; sub_rsp_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_sub_cmd", sub_cmd, 8'h00);
    check("rst_cpu_dout", cpu_dout, 8'hFF);
    check("rst_cpu_doe", cpu_doe, 1'b0);
    check("rst_valid", sub_cmd_valid, 1'b0);
    check("rst_tx_bsy", tx_bsy, 1'b0);
    check("rst_tx_drop", tx_drop, 1'b0);
    check("rst_rx_bsy", rx_bsy, 1'b1);
    check("rst_ready", sub_rsp_ready, 1'b1);

    // Held write: one command only, even with an ack arriving mid-strobe.
    cs = 1'b1; wr_n = 1'b0; cpu_din = 8'hE3;
    cmd_q.push_back(8'hE3);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 5) sub_cmd_ack = 1'b0;
      check("e3_valid", sub_cmd_valid, (i <= 4) ? 1'b1 : 1'b0);
      check("e3_tx_bsy", tx_bsy, (i <= 4) ? 1'b1 : 1'b0);
      check("e3_tx_drop", tx_drop, 1'b0);
      if (i == 4) begin
        check("e3_cmd", sub_cmd, cmd_q.pop_front());
        sub_cmd_ack = 1'b1;
      end
    end
    cs = 1'b0; wr_n = 1'b1;
    tick();
    check("e3_cmd_hold", sub_cmd, 8'hE3);

    // Second write while pending is dropped with a single pulse.
    cs = 1'b1; wr_n = 1'b0; cpu_din = 8'h11;
    cmd_q.push_back(8'h11);
    tick(); tick();
    cs = 1'b0; wr_n = 1'b1;
    tick();
    check("w11_valid", sub_cmd_valid, 1'b1);
    cs = 1'b1; wr_n = 1'b0; cpu_din = 8'h22;
    drops = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 3) begin cs = 1'b0; wr_n = 1'b1; end
      if (tx_drop === 1'b1) drops++;
    end
    check("tx_drop_once", drops, 1);
    check("w22_dropped_cmd", sub_cmd, 8'h11);
    cmd_ack("w11");
    cs = 1'b1; wr_n = 1'b0; cpu_din = 8'h22;
    cmd_q.push_back(8'h22);
    tick();
    check("w22_valid", sub_cmd_valid, 1'b1);
    check("w22_no_drop", tx_drop, 1'b0);
    cs = 1'b0; wr_n = 1'b1;
    tick();
    cmd_ack("w22");

    // FIFO fill, hold-off when full, drain in order, then an empty read.
    for (int k = 0; k < 10; k++) begin
      check($sformatf("vec%0d_ready", k), sub_rsp_ready, vt[k].exp_ready);
      check($sformatf("vec%0d_rx_bsy", k), rx_bsy, vt[k].exp_rx_bsy);
      if (vt[k].is_read) do_read(2, $sformatf("vec%0d_rd", k));
      else do_push(vt[k].din);
    end
    check("drain_rx_bsy", rx_bsy, 1'b1);
    check("drain_ready", sub_rsp_ready, 1'b1);

    // Fall-through: a read starting the cycle after a push sees the byte.
    do_push(8'h5C);
    check("ft_rx_bsy", rx_bsy, 1'b0);
    do_read(2, "ft_rd");
    check("ft_empty", rx_bsy, 1'b1);

    // Push coinciding with the pop at read end keeps count at one.
    do_push(8'h10);
    cs = 1'b1; rd_n = 1'b0;
    tick();
    check("same_rd_dout", cpu_dout, rsp_q.pop_front());
    mdl_cnt--;
    cs = 1'b0; rd_n = 1'b1;
    do_push(8'h20);
    check("same_rx_bsy", rx_bsy, 1'b0);
    do_read(2, "same_rd2");
    check("same_empty", rx_bsy, 1'b1);

    // Reset with a pending command and queued bytes, write strobe held across it.
    cs = 1'b1; wr_n = 1'b0; cpu_din = 8'h33;
    tick();
    cs = 1'b0; wr_n = 1'b1;
    do_push(8'h01); do_push(8'h02); do_push(8'h03);
    check("pre_rst_valid", sub_cmd_valid, 1'b1);
    check("pre_rst_rx_bsy", rx_bsy, 1'b0);
    reset = 1'b1; cs = 1'b1; wr_n = 1'b0; cpu_din = 8'h77;
    tick();
    reset = 1'b0;
    rsp_q.delete(); cmd_q.delete(); mdl_cnt = 0;
    check("mid_rst_valid", sub_cmd_valid, 1'b0);
    check("mid_rst_rx_bsy", rx_bsy, 1'b1);
    check("mid_rst_dout", cpu_dout, 8'hFF);
    check("mid_rst_cmd", sub_cmd, 8'h00);
    check("mid_rst_ready", sub_rsp_ready, 1'b1);
    tick();
    check("post_rst_cmd", sub_cmd, 8'h77);
    check("post_rst_valid", sub_cmd_valid, 1'b1);
    cs = 1'b0; wr_n = 1'b1;
    tick();
    do_read(1, "post_rst_rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
